// File: rtl/conv_window_scheduler.sv
// conv_window_scheduler: walks kernel taps for each of N*N output pixels over an
// N*K x N*K input tile, issues input/weight reads, accumulates the returned
// products and presents each finished pixel on a valid/ready port.
//   clk, rst_n        clock, asynchronous active-low reset
//   start             begin a pass (sampled only when idle)
//   stride            window step, latched at start
//   kernel_width      active kernel edge, latched at start (0 or >K means K)
//   in_rd, in_addr    input RAM read strobe and address
//   w_addr            weight RAM address (read with in_rd)
//   in_data, w_data   signed operands, valid the cycle after in_rd
//   out_valid/ready   pixel handshake; out_data signed sum, out_pixel index
//   busy, done        pass in progress; one-cycle pulse after the last pixel
// Optional build macro CONV_WINDOW_SCHEDULER_RELU_EN clamps negative sums to 0.
module conv_window_scheduler #(
    parameter int K    = 3,
    parameter int N    = 2,
    parameter int DW   = 8,
    parameter int AW   = $clog2(N*N*K*K),
    parameter int ACCW = 2*DW + $clog2(K*K)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [$clog2(K)-1:0]    stride,
    input  logic [$clog2(K)-1:0]    kernel_width,
    output logic                    in_rd,
    output logic [AW-1:0]           in_addr,
    input  logic [DW-1:0]           in_data,
    output logic [$clog2(K*K)-1:0]  w_addr,
    input  logic [DW-1:0]           w_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACCW-1:0]         out_data,
    output logic [$clog2(N*N)-1:0]  out_pixel,
    output logic                    busy,
    output logic                    done
);
    localparam int SW  = $clog2(K);
    localparam int TW  = $clog2(K+1);
    localparam int PW  = $clog2(N+1);
    localparam int WAW = $clog2(K*K);
    localparam int OPW = $clog2(N*N);

    typedef enum logic [2:0] {IDLE, READ, DRAIN, OUT, DONE} state_t;

    state_t                 state;
    logic [SW-1:0]          stride_q;
    logic [TW-1:0]          kw, tap_r, tap_c;
    logic [PW-1:0]          pix_r, pix_c;
    logic                   pend;
    logic signed [ACCW-1:0] acc;

    logic [TW-1:0]          kw_eff, kw_m1, nxt_tr, nxt_tc;
    logic [PW-1:0]          nxt_pr, nxt_pc;
    logic                   tap_wrap, last_tap, pix_wrap, last_pix;
    logic signed [2*DW-1:0] prod;
    logic signed [ACCW-1:0] acc_nxt, res;

    function automatic logic [AW-1:0] in_addr_f(input logic [TW-1:0] tr, input logic [TW-1:0] tc,
                                                 input logic [PW-1:0] pr, input logic [PW-1:0] pc,
                                                 input logic [SW-1:0] s);
        return AW'((int'(tr) + int'(s) * int'(pr)) * (N*K) + int'(tc) + int'(s) * int'(pc));
    endfunction

    function automatic logic [WAW-1:0] w_addr_f(input logic [TW-1:0] tr, input logic [TW-1:0] tc);
        return WAW'(int'(tr) * K + int'(tc));
    endfunction

    assign kw_eff   = (kernel_width == '0 || int'(kernel_width) > K) ? TW'(K) : TW'(kernel_width);
    assign kw_m1    = kw - TW'(1);
    assign tap_wrap = tap_c == kw_m1;
    assign last_tap = tap_wrap && tap_r == kw_m1;
    assign nxt_tc   = tap_wrap ? '0 : tap_c + TW'(1);
    assign nxt_tr   = tap_wrap ? tap_r + TW'(1) : tap_r;
    assign pix_wrap = pix_c == PW'(N-1);
    assign last_pix = pix_wrap && pix_r == PW'(N-1);
    assign nxt_pc   = pix_wrap ? '0 : pix_c + PW'(1);
    assign nxt_pr   = pix_wrap ? pix_r + PW'(1) : pix_r;
    assign prod     = $signed(in_data) * $signed(w_data);
    // pend marks the cycle whose operands answer the previous cycle's read
    assign acc_nxt  = acc + (pend ? ACCW'(prod) : '0);
`ifdef CONV_WINDOW_SCHEDULER_RELU_EN
    assign res      = acc_nxt[ACCW-1] ? '0 : acc_nxt;
`else
    assign res      = acc_nxt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            stride_q  <= '0;
            kw        <= '0;
            tap_r     <= '0;
            tap_c     <= '0;
            pix_r     <= '0;
            pix_c     <= '0;
            pend      <= 1'b0;
            acc       <= '0;
            in_rd     <= 1'b0;
            in_addr   <= '0;
            w_addr    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_pixel <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            pend <= in_rd;
            acc  <= acc_nxt;
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    stride_q <= stride;
                    kw       <= kw_eff;
                    pix_r    <= '0;
                    pix_c    <= '0;
                    tap_r    <= '0;
                    tap_c    <= '0;
                    in_rd    <= 1'b1;
                    in_addr  <= '0;
                    w_addr   <= '0;
                    acc      <= '0;
                    busy     <= 1'b1;
                    state    <= READ;
                end
                // tap_r/tap_c always name the tap currently on the address bus
                READ: if (last_tap) begin
                    in_rd <= 1'b0;
                    state <= DRAIN;
                end else begin
                    tap_r   <= nxt_tr;
                    tap_c   <= nxt_tc;
                    in_addr <= in_addr_f(nxt_tr, nxt_tc, pix_r, pix_c, stride_q);
                    w_addr  <= w_addr_f(nxt_tr, nxt_tc);
                end
                DRAIN: begin
                    out_data  <= ACCW'(res);
                    out_pixel <= OPW'(int'(pix_r) * N + int'(pix_c));
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    if (last_pix) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        pix_r   <= nxt_pr;
                        pix_c   <= nxt_pc;
                        tap_r   <= '0;
                        tap_c   <= '0;
                        in_rd   <= 1'b1;
                        in_addr <= in_addr_f(TW'(0), TW'(0), nxt_pr, nxt_pc, stride_q);
                        w_addr  <= '0;
                        acc     <= '0;
                        state   <= READ;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_window_scheduler.sv
// tb_conv_window_scheduler: directed bench for conv_window_scheduler with a
// synchronous input/weight RAM model and hand-computed expected pixels.
module tb_conv_window_scheduler;
    localparam int K = 3, N = 2, DW = 8, AW = 6, ACCW = 20;

    logic            clk = 1'b0, rst_n = 1'b1, start = 1'b0, out_ready = 1'b1;
    logic [1:0]      stride = '0, kernel_width = '0;
    logic            in_rd, out_valid, busy, done;
    logic [AW-1:0]   in_addr;
    logic [3:0]      w_addr;
    logic [DW-1:0]   in_data = '0, w_data = '0;
    logic [ACCW-1:0] out_data;
    logic [1:0]      out_pixel;

    conv_window_scheduler #(.K(K), .N(N), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stride(stride), .kernel_width(kernel_width),
        .in_rd(in_rd), .in_addr(in_addr), .in_data(in_data), .w_addr(w_addr), .w_data(w_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_pixel(out_pixel),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [36];
    logic [DW-1:0] wmem [9];
    always @(posedge clk) if (in_rd) begin
        in_data <= mem[in_addr];
        w_data  <= wmem[w_addr];
    end

    int checks = 0, failures = 0, passes = 0, overlap = 0;
    int addr_q[$];
    always @(negedge clk) begin
        if (done) passes++;
        if (in_rd && out_valid) overlap++;
        if (in_rd) addr_q.push_back(int'(in_addr));
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_w(input int v);
        for (int i = 0; i < 9; i++) wmem[i] = 8'(v);
    endtask

    task automatic start_pass(input int s, input int k);
        @(negedge clk);
        stride = 2'(s);
        kernel_width = 2'(k);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // c0: cycles from the post-start negedge to the first valid; cyc: handshake to next valid
    task automatic collect(input string tag, input int e0, input int e1, input int e2, input int e3,
                           input int c0, input int cyc, input int hold);
        int exp_d[4];
        int n, d0, x0, bad;
        exp_d = '{e0, e1, e2, e3};
        for (int p = 0; p < 4; p++) begin
            n = 1;
            while (!out_valid && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (!out_valid) begin
                chk({tag, "_timeout"}, 0, 1);
                return;
            end
            chk({tag, "_cycles"}, n, p == 0 ? c0 : cyc);
            chk({tag, "_data"}, int'($signed(out_data)), exp_d[p]);
            chk({tag, "_pixel"}, int'(out_pixel), p);
            if (p == 0 && hold > 0) begin
                d0 = int'(out_data);
                x0 = int'(out_pixel);
                bad = 0;
                repeat (hold) begin
                    @(negedge clk);
                    if (!out_valid || int'(out_data) != d0 || int'(out_pixel) != x0 || in_rd) bad++;
                end
                chk({tag, "_hold"}, bad, 0);
                out_ready = 1'b1;
            end
            @(negedge clk);
            if (p == 3) begin
                chk({tag, "_done"}, int'(done), 1);
                chk({tag, "_busy_done"}, int'(busy), 1);
                @(negedge clk);
                chk({tag, "_done_end"}, int'(done), 0);
                chk({tag, "_busy_end"}, int'(busy), 0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ea[9];
        int pc;
        ea = '{0, 1, 2, 6, 7, 8, 12, 13, 14};
        for (int i = 0; i < 36; i++) mem[i] = 8'(i);
        set_w(1);
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_rd", int'(in_rd), 0);
        chk("rst_data", int'(out_data), 0);
        @(negedge clk);
        rst_n = 1'b1;

        addr_q.delete();
        start_pass(1, 3);
        collect("s1k3", 63, 72, 117, 126, 11, 11, 0);
        for (int i = 0; i < 9; i++) chk("addr_p0", addr_q.size() > i ? addr_q[i] : -1, ea[i]);
        chk("passes1", passes, 1);

        start_pass(2, 3);
        collect("s2k3", 63, 81, 171, 189, 11, 11, 0);

        start_pass(2, 1);
        collect("s2k1", 0, 2, 12, 14, 3, 3, 0);

        start_pass(1, 0);
        collect("kw0", 63, 72, 117, 126, 11, 11, 0);

        start_pass(0, 2);
        collect("s0k2", 14, 14, 14, 14, 6, 6, 0);

        out_ready = 1'b0;
        start_pass(1, 3);
        collect("bp", 63, 72, 117, 126, 11, 11, 5);

        set_w(-1);
        start_pass(1, 3);
`ifdef CONV_WINDOW_SCHEDULER_RELU_EN
        collect("neg", 0, 0, 0, 0, 11, 11, 0);
`else
        collect("neg", -63, -72, -117, -126, 11, 11, 0);
`endif
        set_w(1);

        pc = passes;
        start_pass(1, 3);
        repeat (3) @(negedge clk);
        stride = 2'd2;
        kernel_width = 2'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        collect("ign", 63, 72, 117, 126, 7, 11, 0);
        repeat (3) @(negedge clk);
        chk("ign_passes", passes, pc + 1);
        chk("ign_idle", int'(busy), 0);

        pc = passes;
        start_pass(1, 3);
        repeat (23) @(negedge clk);
        chk("pre_rst_rd", int'(in_rd), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_rd", int'(in_rd), 0);
        chk("arst_addr", int'(in_addr), 0);
        chk("arst_waddr", int'(w_addr), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_pixel", int'(out_pixel), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("arst_passes", passes, pc);
        chk("arst_idle", int'(busy), 0);

        start_pass(1, 3);
        collect("recover", 63, 72, 117, 126, 11, 11, 0);

        chk("overlap", overlap, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/conv_window_scheduler.md
# conv_window_scheduler

Sequences one full convolution pass over an N·K × N·K input tile stored in a synchronous RAM: for each of the N·N output pixels it walks the active kernel taps, generates input and weight read addresses, multiply-accumulates the returned operands, and hands the finished pixel downstream over a valid/ready port. It sits between the tile/weight buffers and the output stage, and it owns the flattened-index arithmetic (tap row/col + stride·pixel row/col) that maps kernel taps onto the input tile.

## Interface
- K, 3, maximum kernel edge; weight buffer holds K·K taps
- N, 2, output edge; N·N output pixels per pass
- DW, 8, signed input/weight data width
- AW, $clog2(N*N*K*K), input RAM address width
- ACCW, 2*DW+$clog2(K*K), signed accumulator/output width

- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a pass; sampled only in IDLE
- stride  in  $clog2(K)  window step, latched at start
- kernel_width  in  $clog2(K)  active kernel edge, latched at start; 0 or >K treated as K
- in_rd  out  1  input RAM read strobe
- in_addr  out  AW  input RAM address, (tap_r + stride·pix_r)·(N·K) + (tap_c + stride·pix_c)
- in_data  in  DW  signed, valid the cycle after in_rd
- w_addr  out  $clog2(K*K)  weight address, tap_r·K + tap_c
- w_data  in  DW  signed, valid the cycle after in_rd
- out_valid  out  1  finished pixel available
- out_ready  in  1  downstream accepts
- out_data  out  ACCW  signed accumulated pixel
- out_pixel  out  $clog2(N*N)  pixel index, pix_r·N + pix_c
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after last pixel accepted

## Operation
- FSM: IDLE → READ → DRAIN → OUT → (READ for next pixel | DONE) ; DONE → IDLE.
- IDLE: on start=1 latch stride and effective kw, clear pixel counters (pix_r, pix_c), go READ.
- READ: accumulator cleared on entry; one tap issued per cycle, in_rd=1; tap_c increments 0..kw-1, wraps and increments tap_r 0..kw-1; after tap (kw-1,kw-1) go DRAIN.
- Every cycle after an in_rd cycle: acc ← acc + in_data·w_data (signed, full ACCW, no saturation).
- DRAIN: accumulates last tap, in_rd=0, go OUT.
- OUT: out_valid=1, out_data/out_pixel held stable until out_ready=1; on handshake advance pix_c (wrap to 0, increment pix_r); if last pixel (N-1,N-1) go DONE else READ.
- DONE: done=1 for exactly one cycle, go IDLE.
- Addresses computed from counters (no divide/modulo); max index (K-1)(N-1)+K−1 < N·K, so no out-of-range address for any legal stride/kw.
- stride=0 legal: every pixel reads the same window.
- start while busy=1 ignored; stride/kernel_width changes mid-pass ignored.
- Reset (any state): FSM→IDLE, counters and accumulator 0; in_rd, in_addr, w_addr, out_valid, out_data, out_pixel, busy, done all 0.

## Timing
- start sampled at cycle t → taps issued t+1..t+kw², DRAIN at t+kw²+1, out_valid from t+kw²+2.
- Handshake at cycle h → next pixel's first tap at h+1; per-pixel cost kw²+2 cycles at full out_ready.
- Last handshake at h → done=1 at h+1, busy=0 and start accepted from h+2.
- in_rd never asserted while out_valid=1 (no read overlap with backpressure).

## Configuration
- CONV_WINDOW_SCHEDULER_RELU_EN defined: out_data = 0 when accumulator negative, else accumulator.
- Undefined: out_data = raw signed accumulator. Timing identical in both builds.

## Test plan
- K=3,N=2, in[i]=i, weights all 1, stride=1, kw=3 → in_addr pixel0 = 0,1,2,6,7,8,12,13,14; out_data = 63, 72, 117, 126 for out_pixel 0..3; done one cycle after 4th handshake.
- Same data, stride=2, kw=3 → out_data 63, 81, 171, 189.
- kw=1, stride=2, weights all 1 → out_data 0, 2, 12, 14; 3 cycles per pixel with out_ready=1.
- out_ready low 5 cycles during OUT → out_valid, out_data, out_pixel stable, in_rd=0 throughout; pass resumes on release.
- Weights all −1, stride=1, kw=3 → with RELU_EN out_data 0 for all pixels; without, −63, −72, −117, −126.
- rst_n low mid-READ of pixel 2 → all outputs 0 immediately, busy=0; start pulsed during busy → ignored, pass count unchanged.
